// File: rtl/rom_arb_pkg.sv
// Shared types and widths for the ROM channel arbiter: return tag layout and width helpers.
package rom_arb_pkg;

  localparam int unsigned DEF_ROM_ADDR_W  = 16;
  localparam int unsigned DEF_SEL_W       = 5;
  localparam int unsigned DEF_BYTE_ADDR_W = DEF_ROM_ADDR_W + DEF_SEL_W;

  // Tag fields are sized for the largest legal configuration (16 channels, 8 select bits).
  localparam int unsigned TAG_CH_W  = 4;
  localparam int unsigned TAG_SEL_W = 8;

  typedef struct packed {
    logic [TAG_CH_W-1:0]  chan;
    logic [TAG_SEL_W-1:0] sel;
    logic                 err;
  } tag_t;

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned byte_addr_width(input int unsigned rom_addr_w,
                                                  input int unsigned sel_w);
    return rom_addr_w + sel_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: lowest requester at or after the pointer, wrapping.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  logic [NUM_CH-1:0] rot;
  int                off;
  int                sum;

  always_comb begin
    // Rotate so the pointer position lands on bit 0, then take the lowest set bit.
    rot = NUM_CH'({req_i, req_i} >> ptr_i);
    off = 0;
    for (int p = NUM_CH - 1; p >= 0; p--) begin
      if (rot[p]) begin
        off = p;
      end
    end
    sum = 32'(ptr_i) + off;
    if (sum >= NUM_CH) begin
      sum = sum - NUM_CH;
    end
    gnt_valid_o = |rot;
    gnt_idx_o   = CH_W'(sum);
    gnt_o       = gnt_valid_o ? (NUM_CH'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/rom_channel_arbiter.sv
// Shares one wide synchronous ROM among NUM_CH byte-read channels with round-robin,
// one-issue-per-cycle access and a tagged return pipeline matched to the ROM latency.
module rom_channel_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ROM_WORD_W  = 256,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SEL_W       = DEF_SEL_W,
  parameter int unsigned ROM_ADDR_W  = DEF_ROM_ADDR_W,
  parameter int unsigned IDX_W       = 16,
  parameter int unsigned ROM_LATENCY = 2
) (
  input  logic                                CLK_50Mhz,
  input  logic                                reset_n,
  input  logic [NUM_CH-1:0]                   ch_req,
  input  logic [NUM_CH*IDX_W-1:0]             ch_index,
  input  logic [NUM_CH*(ROM_ADDR_W+SEL_W)-1:0] ch_base,
  input  logic [NUM_CH*IDX_W-1:0]             ch_limit,
  output logic [NUM_CH-1:0]                   ch_ack,
  output logic [NUM_CH-1:0]                   ch_valid,
  output logic [NUM_CH-1:0]                   ch_err,
  output logic [NUM_CH*DATA_W-1:0]            ch_data,
  output logic [ROM_ADDR_W-1:0]               rom_address,
  input  logic [ROM_WORD_W-1:0]               rom_q
);

  localparam int unsigned CH_W  = ch_width(NUM_CH);
  localparam int unsigned BA_W  = byte_addr_width(ROM_ADDR_W, SEL_W);
  // One extra stage: the tag must line up with rom_q as sampled on the edge after it settles.
  localparam int unsigned DEPTH = ROM_LATENCY + 1;

  logic [NUM_CH-1:0]              pending_q;
  logic [CH_W-1:0]                ptr_q;
  logic [NUM_CH-1:0]              ack_q, valid_q, err_q;
  logic [NUM_CH-1:0][DATA_W-1:0]  data_q;
  logic [ROM_ADDR_W-1:0]          rom_address_q;
  tag_t                           tag_q [DEPTH];
  logic [DEPTH-1:0]               tag_vld_q;

  logic [NUM_CH-1:0] eligible, gnt_onehot, ret_onehot;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_valid;
  logic [IDX_W-1:0]  g_index, g_limit;
  logic [BA_W-1:0]   g_base, byte_addr;
  tag_t              tag_in, tag_out;
  logic [DATA_W-1:0] ret_byte;

  assign eligible = ch_req & ~pending_q;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_arbiter (
    .req_i       (eligible),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt_onehot),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    g_index     = ch_index[32'(gnt_idx)*IDX_W +: IDX_W];
    g_limit     = ch_limit[32'(gnt_idx)*IDX_W +: IDX_W];
    g_base      = ch_base[32'(gnt_idx)*BA_W +: BA_W];
    byte_addr   = g_base + BA_W'(g_index);
    tag_in      = '0;
    tag_in.chan = TAG_CH_W'(gnt_idx);
    tag_in.sel  = TAG_SEL_W'(byte_addr[SEL_W-1:0]);
    tag_in.err  = g_index > g_limit;
  end

  always_comb begin
    tag_out    = tag_q[DEPTH-1];
    ret_onehot = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (tag_vld_q[DEPTH-1] && (32'(tag_out.chan) == c)) begin
        ret_onehot[c] = 1'b1;
      end
    end
    ret_byte = tag_out.err ? '0 : rom_q[32'(tag_out.sel)*DATA_W +: DATA_W];
  end

  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      pending_q     <= '0;
      ptr_q         <= '0;
      ack_q         <= '0;
      valid_q       <= '0;
      err_q         <= '0;
      data_q        <= '0;
      rom_address_q <= '0;
      tag_vld_q     <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ack_q     <= gnt_onehot;
      valid_q   <= ret_onehot;
      err_q     <= tag_out.err ? ret_onehot : '0;
      // A returning channel is never the one being granted, so clear and set cannot collide.
      pending_q <= (pending_q & ~ret_onehot) | gnt_onehot;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ret_onehot[c]) begin
          data_q[c] <= ret_byte;
        end
      end
      if (gnt_valid) begin
        rom_address_q <= byte_addr[BA_W-1 -: ROM_ADDR_W];
        if (32'(gnt_idx) == NUM_CH - 1) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= gnt_idx + 1'b1;
        end
      end
      tag_vld_q <= {tag_vld_q[DEPTH-2:0], gnt_valid};
      tag_q[0]  <= tag_in;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign ch_ack      = ack_q;
  assign ch_valid    = valid_q;
  assign ch_err      = err_q;
  assign ch_data     = data_q;
  assign rom_address = rom_address_q;

endmodule
